// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle.
//   opcode      : instruction register upper nibble (datapath -> sequencer)
//   carry_flag  : latched ALU carry                 (datapath -> sequencer)
//   zero_flag   : latched ALU zero                  (datapath -> sequencer)
//   control     : 16-bit control word               (sequencer -> datapath)
//   step        : current T-state 0..4              (sequencer -> datapath)
//   halted      : HLT has executed                  (sequencer -> datapath)
interface control_sequencer_if;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned STEP_W = 3;

    logic [OP_W-1:0]   opcode;
    logic              carry_flag;
    logic              zero_flag;
    logic [CTRL_W-1:0] control;
    logic [STEP_W-1:0] step;
    logic              halted;

    // Datapath side
    modport master (
        output opcode, carry_flag, zero_flag,
        input  control, step, halted
    );

    // Sequencer side
    modport slave (
        input  opcode, carry_flag, zero_flag,
        output control, step, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit computer: steps T0..T4 and decodes
// (step, opcode, flags) into the control word for the register bank.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : control_sequencer_if.slave (opcode/flags in, control/step/halted out)
// control is combinational from the registered step/halted state.
module control_sequencer #(
    parameter bit EARLY_END = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    control_sequencer_if.slave   bus
);
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned OP_W   = 4;

    localparam logic [CTRL_W-1:0] W_FETCH0 = 16'h4004; // MI|CO
    localparam logic [CTRL_W-1:0] W_FETCH1 = 16'h1408; // RO|II|CE
    localparam logic [CTRL_W-1:0] W_IR_MAR = 16'h4800; // MI|IO
    localparam logic [CTRL_W-1:0] W_RAM_A  = 16'h1200; // RO|AI
    localparam logic [CTRL_W-1:0] W_RAM_B  = 16'h1020; // RO|BI
    localparam logic [CTRL_W-1:0] W_ADD    = 16'h0281; // AI|EO|FI
    localparam logic [CTRL_W-1:0] W_SUB    = 16'h02C1; // AI|EO|SU|FI
    localparam logic [CTRL_W-1:0] W_A_RAM  = 16'h2100; // RI|AO
    localparam logic [CTRL_W-1:0] W_IR_A   = 16'h0A00; // IO|AI
    localparam logic [CTRL_W-1:0] W_JUMP   = 16'h0802; // IO|J
    localparam logic [CTRL_W-1:0] W_OUT    = 16'h0110; // AO|OI
    localparam logic [CTRL_W-1:0] W_HLT    = 16'h8000; // HLT

    localparam logic [OP_W-1:0] OP_LDA = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OP_W-1:0] OP_STA = 4'b0100;
    localparam logic [OP_W-1:0] OP_LDI = 4'b0101;
    localparam logic [OP_W-1:0] OP_JMP = 4'b0110;
    localparam logic [OP_W-1:0] OP_JC  = 4'b0111;
    localparam logic [OP_W-1:0] OP_JZ  = 4'b1000;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam logic [STEP_W-1:0] S0 = 3'd0;
    localparam logic [STEP_W-1:0] S1 = 3'd1;
    localparam logic [STEP_W-1:0] S2 = 3'd2;
    localparam logic [STEP_W-1:0] S3 = 3'd3;
    localparam logic [STEP_W-1:0] S4 = 3'd4;

    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d;
    logic [CTRL_W-1:0] word;

    // Microcode decode of the current step
    always_comb begin
        word = '0;
        if (step_q == S0) begin
            word = W_FETCH0;
        end else if (step_q == S1) begin
            word = W_FETCH1;
        end else begin
            case (bus.opcode)
                OP_LDA: begin
                    if (step_q == S2) word = W_IR_MAR;
                    if (step_q == S3) word = W_RAM_A;
                end
                OP_ADD, OP_SUB: begin
                    if (step_q == S2) word = W_IR_MAR;
                    if (step_q == S3) word = W_RAM_B;
                    if (step_q == S4) word = (bus.opcode == OP_SUB) ? W_SUB : W_ADD;
                end
                OP_STA: begin
                    if (step_q == S2) word = W_IR_MAR;
                    if (step_q == S3) word = W_A_RAM;
                end
                OP_LDI: if (step_q == S2) word = W_IR_A;
                OP_JMP: if (step_q == S2) word = W_JUMP;
                OP_JC:  if (step_q == S2 && bus.carry_flag) word = W_JUMP;
                OP_JZ:  if (step_q == S2 && bus.zero_flag)  word = W_JUMP;
                OP_OUT: if (step_q == S2) word = W_OUT;
                OP_HLT: if (step_q == S2) word = W_HLT;
                default: word = '0;
            endcase
        end
    end

    // Step advance; a zero word at step >= 2 still occupies its cycle
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (step_q == S2 && word[15]) begin
                halted_d = 1'b1;
            end else if (step_q == S4) begin
                step_d = S0;
            end else if (EARLY_END && step_q >= S2 && word == '0) begin
                step_d = S0;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q   <= S0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Reset forces the word low without waiting for an edge
    assign bus.control = reset    ? '0
                       : halted_q ? W_HLT
                       : word;
    assign bus.step    = step_q;
    assign bus.halted  = halted_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: expected (step, halted, control)
// triples are queued as each scenario is driven and popped one per cycle.
module tb_control_sequencer;
    logic clk;
    logic reset;

    control_sequencer_if bus();
    control_sequencer_if bus_ne();

    control_sequencer #(.EARLY_END(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    control_sequencer #(.EARLY_END(1'b0)) dut_ne (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_ne)
    );

    typedef struct packed {
        logic [2:0]  step;
        logic        halted;
        logic [15:0] control;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_cmp;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [2:0] s, input logic h, input logic [15:0] c);
        exp_t x;
        x.step = s; x.halted = h; x.control = c;
        sb_q.push_back(x);
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 4'b0010; bus.carry_flag = 1'b0; bus.zero_flag = 1'b0;
        bus_ne.opcode = 4'b0000; bus_ne.carry_flag = 1'b0; bus_ne.zero_flag = 1'b0;
        #2;
        n_cmp++;
        if ({bus.step, bus.halted, bus.control} !== {3'd0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_hold: got step=%0d halted=%0d control=0x%04h want 0/0/0x0000",
                     bus.step, bus.halted, bus.control);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h4800);
        push(3, 0, 16'h1020); push(4, 0, 16'h0281); push(0, 0, 16'h4004);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL reset_add: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
    endtask

    task automatic test_lda_nop();
        bus.opcode = 4'b0001;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h4800);
        push(3, 0, 16'h1200); push(4, 0, 16'h0000); push(0, 0, 16'h4004);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL lda: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
        bus.opcode = 4'b0000;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h0000);
        push(0, 0, 16'h4004);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL nop: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
    endtask

    task automatic test_cond_jump();
        // JC untaken, JC taken, JZ untaken, JZ taken, then LDI and OUT lengths
        bus.opcode = 4'b0111; bus.carry_flag = 1'b0; bus.zero_flag = 1'b1;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h0000);
        push(0, 0, 16'h4004);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL jc_untaken: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
        bus.carry_flag = 1'b1; bus.zero_flag = 1'b0;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h0802);
        push(3, 0, 16'h0000); push(0, 0, 16'h4004);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL jc_taken: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
        bus.opcode = 4'b1000; bus.carry_flag = 1'b1; bus.zero_flag = 1'b0;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h0000);
        push(0, 0, 16'h4004);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL jz_untaken: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
        bus.carry_flag = 1'b0; bus.zero_flag = 1'b1;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h0802);
        push(3, 0, 16'h0000); push(0, 0, 16'h4004);
        bus.zero_flag = 1'b1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL jz_taken: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
        bus.zero_flag = 1'b0;
        bus.opcode = 4'b0101;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h0A00);
        push(3, 0, 16'h0000); push(0, 0, 16'h4004);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL ldi: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
        bus.opcode = 4'b1110;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h0110);
        push(3, 0, 16'h0000); push(0, 0, 16'h4004);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL out: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
    endtask

    task automatic test_async_reset_sub();
        bus.opcode = 4'b0011;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h4800);
        push(3, 0, 16'h1020);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL sub_pre: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.step, bus.halted, bus.control} !== {3'd0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL async_reset: got %0d/%0d/0x%04h want 0/0/0x0000",
                     bus.step, bus.halted, bus.control);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h4800);
        push(3, 0, 16'h1020); push(4, 0, 16'h02C1); push(0, 0, 16'h4004);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL sub_full: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
    endtask

    task automatic test_halt();
        bus.opcode = 4'b1111;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h8000);
        for (int i = 0; i < 10; i++) push(2, 1, 16'h8000);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL halt: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.step, bus.halted, bus.control} !== {3'd0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL halt_reset: got %0d/%0d/0x%04h want 0/0/0x0000",
                     bus.step, bus.halted, bus.control);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.opcode = 4'b0000;
        #1;
        push(0, 0, 16'h4004); push(1, 0, 16'h1408);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.step, bus.halted, bus.control} !== e) begin
                n_fail++;
                $display("FAIL halt_resume: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                         bus.step, bus.halted, bus.control, e.step, e.halted, e.control);
            end
            if (sb_q.size() > 0) next_cycle();
        end
    endtask

    task automatic test_no_early_end();
        int waited;
        waited = 0;
        while (bus_ne.step !== 3'd0 && waited < 6) begin
            next_cycle();
            waited++;
        end
        n_cmp++;
        if (bus_ne.step !== 3'd0) begin
            n_fail++;
            $display("FAIL ne_sync: step %0d never returned to 0 within 6 cycles", bus_ne.step);
        end else begin
            push(0, 0, 16'h4004); push(1, 0, 16'h1408); push(2, 0, 16'h0000);
            push(3, 0, 16'h0000); push(4, 0, 16'h0000); push(0, 0, 16'h4004);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({bus_ne.step, bus_ne.halted, bus_ne.control} !== e) begin
                    n_fail++;
                    $display("FAIL no_early_end: got %0d/%0d/0x%04h want %0d/%0d/0x%04h",
                             bus_ne.step, bus_ne.halted, bus_ne.control,
                             e.step, e.halted, e.control);
                end
                if (sb_q.size() > 0) next_cycle();
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_lda_nop();
        test_cond_jump();
        test_async_reset_sub();
        test_halt();
        test_no_early_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcode sequencer for the 8-bit computer. It advances a T-state step counter and decodes the current opcode and step into the control word that drives every register's input/output enables, the ALU and the program counter. It sits directly upstream of the register bank: each register enable it produces is sampled by that register on the next rising clock edge.

## Interface
- `EARLY_END`, default 1: when 1, a step ≥2 whose decoded control word is all-zero ends the instruction early.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `opcode`  input  4  upper nibble of the instruction register; valid from step 2.
- `carry_flag`  input  1  latched ALU carry from the flags register.
- `zero_flag`  input  1  latched ALU zero from the flags register.
- `control`  output  16  control word. Bit map: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
- `step`  output  3  current T-state, 0–4.
- `halted`  output  1  high once HLT has executed.

## Operation
- State is the step counter (0–4) plus a halted latch. `control` is decoded combinationally from `step`, `opcode` and the flags.
- Fetch, same for all opcodes:
  - step 0: `0x4004` (MI|CO)
  - step 1: `0x1408` (RO|II|CE)
- Execute words. Steps not listed are `0x0000`:
  - 0000 NOP: none.
  - 0001 LDA: s2 `0x4800`, s3 `0x1200`.
  - 0010 ADD: s2 `0x4800`, s3 `0x1020`, s4 `0x0281`.
  - 0011 SUB: s2 `0x4800`, s3 `0x1020`, s4 `0x02C1`.
  - 0100 STA: s2 `0x4800`, s3 `0x2100`.
  - 0101 LDI: s2 `0x0A00`.
  - 0110 JMP: s2 `0x0802`.
  - 0111 JC: s2 `0x0802` if `carry_flag`, else `0x0000`.
  - 1000 JZ: s2 `0x0802` if `zero_flag`, else `0x0000`.
  - 1110 OUT: s2 `0x0110`.
  - 1111 HLT: s2 `0x8000`.
  - Unused opcodes (1001–1101) decode as NOP.
- Step transitions on each rising edge while not halted:
  - step 4 → 0.
  - If `EARLY_END`=1 and step ≥2 and `control`==0: step → 0.
  - Otherwise step → step+1.
  - The zero-word cycle is still consumed; it is not skipped.
- Halt:
  - The edge that ends a step-2 cycle with HLT set sets `halted`=1 and freezes `step` at 2.
  - While halted, `control`=`0x8000` and all other bits are 0.
  - Only `reset` clears `halted`.

## Timing
- Reset asserted: `step`=0, `halted`=0, `control`=`0x0000` (forced, asynchronously).
- After reset release, `control`=`0x4004` until the first rising edge.
- `control` settles combinationally after each edge and is stable before the next edge, where consumers sample it.
- Flag and opcode changes mid-step propagate to `control` within the same cycle; only the value present at the edge matters.
- Instruction length:
  - With `EARLY_END`=1: LDA/STA 5 cycles (the last is idle), ADD/SUB 5, LDI/JMP/OUT 4, NOP and untaken JC/JZ 3.
  - With `EARLY_END`=0: every instruction takes 5 cycles.
- Reset mid-instruction aborts immediately; the first post-reset cycle is fetch step 0.
- `reset` takes priority over halt and over every step transition.

## Test plan
- Reset with opcode=0010 held: during reset `control`=`0x0000`, `step`=0, `halted`=0. After release, edge sequence `0x4004`, `0x1408`, `0x4800`, `0x1020`, `0x0281`, then `step`=0.
- LDA (0001), `EARLY_END`=1: steps 0,1,2,3,4 with words `0x4004`, `0x1408`, `0x4800`, `0x1200`, `0x0000`, then fetch. NOP: steps 0,1,2 then 0.
- JC with `carry_flag`=0: step 2 word `0x0000`, next step 0. Repeat with `carry_flag`=1: step 2 word `0x0802`, next step 3, then step 3 word `0x0000`, next 0.
- `EARLY_END`=0, NOP: steps 0,1,2,3,4,0 with words 0 at steps 2–4.
- HLT (1111): at step 2 `control`=`0x8000`. After that edge, `halted`=1 and `step` stays 2 for 10 cycles with `control`=`0x8000`. Asserting `reset` clears `halted`, and execution resumes at `0x4004`.
- Async reset at step 3 of SUB, between edges: `control` drops to `0x0000` immediately. After release, a full SUB runs with s4 word `0x02C1`.
